serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing D = A - B, LSB first, one bit per clock, through a single full-subtractor cell (A, B, borrow-in -> difference, borrow-out) plus a borrow flip-flop.
- It is the inverse-operation counterpart of the combinational full-adder datapath and serves as the area-cheap subtract unit in the arithmetic library.
- Operands enter and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair A/B is valid.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  minuend, unsigned or two's complement.
- B  in  WIDTH  subtrahend.
- out_valid  out  1  result D and flags are valid.
- out_ready  in  1  consumer accepts the result.
- D  out  WIDTH  difference A - B, modulo 2^WIDTH.
- BORROW  out  1  final borrow-out; 1 iff A < B unsigned.
- V  out  1  signed overflow; equals borrow into MSB XOR borrow out of MSB.
- Z  out  1  1 iff D == 0.

Behaviour:
- Reset values: in_ready=1, out_valid=0, D=0, BORROW=0, V=0, Z=0, state=IDLE, bit counter=0, borrow register=0.
- Reset asserted mid-operation aborts immediately. The partial result is discarded. No out_valid is produced for the aborted operation.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: latch A and B into shift registers, clear borrow register and counter, go to RUN.
  - A/B are sampled only on the accept edge; later input changes are ignored.
- RUN:
  - in_ready=0.
  - Each cycle computes d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - d shifts into the result register from the MSB side, so the result is LSB-aligned after WIDTH shifts. The a/b registers shift right. The borrow register takes bout.
  - Before the MSB step, save the borrow-in for V.
  - After exactly WIDTH RUN cycles, go to DONE.
- DONE:
  - out_valid=1. D, BORROW, V and Z are stable.
  - Hold until out_ready=1. On out_valid&&out_ready, go to IDLE (out_valid=0 the next cycle).
  - in_ready stays 0 in DONE; there is no same-cycle accept.
- Latency and throughput:
  - The accept edge is cycle 0. out_valid rises after cycle WIDTH+1 (first visible cycle WIDTH+1).
  - Minimum initiation interval is WIDTH+2 cycles.
- Z is computed from the full result register at DONE entry (registered), not bit-serially accumulated.
- WIDTH=1: RUN lasts one cycle. V equals the borrow-in XOR borrow-out of the single bit, i.e. (0 ^ BORROW).
- Outputs D/BORROW/V/Z keep their last values in IDLE until the next DONE; they are qualified only by out_valid.
- out_ready asserted while out_valid=0 has no effect. in_valid outside IDLE has no effect, and the operands are not captured.

Test Plan:
- WIDTH=8, A=0x05, B=0x03 -> out_valid at cycle 9: D=0x02, BORROW=0, V=0, Z=0.
- A=0x03, B=0x05 -> D=0xFE, BORROW=1, V=0, Z=0. Then A=0x80, B=0x01 -> D=0x7F, BORROW=0, V=1.
- A=0x5A, B=0x5A -> D=0x00, Z=1, BORROW=0. Then A=0x00, B=0xFF -> D=0x01, BORROW=1, V=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid, and toggle in_valid with new operands during RUN/DONE.
  - Required: D and flags stay stable, in_ready stays 0, out_valid drops the cycle after the handshake, and the next accepted pair is the one presented in IDLE.
- Reset mid-RUN: assert rst at RUN cycle 4 of A=0xF0, B=0x0F -> all outputs at reset values, in_ready=1. A fresh A=0x10, B=0x01 then gives D=0x0F.
- WIDTH=1 build: A=0, B=1 -> D=1, BORROW=1, V=1, out_valid at cycle 2. Random sweep of 1000 pairs at WIDTH=8 vs. reference model: zero mismatches.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Valid/ready operand and result channels of the bit-serial subtractor.
// The master side presents A/B and consumes D plus flags.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             BORROW;
    logic             V;
    logic             Z;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, D, BORROW, V, Z
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, D, BORROW, V, Z
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell plus a borrow flop.
// Results are held in DONE until the consumer takes them.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_bo;
    logic             r_v;
    logic             r_z;

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_a0   = r_a[0];
    assign w_b0   = r_b[0];
    assign w_d    = w_a0 ^ w_b0 ^ r_borrow;
    assign w_bout = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // New difference bit enters at the MSB so the word ends LSB-aligned
    assign w_res_next = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bo        <= 1'b0;
            r_v         <= 1'b0;
            r_z         <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.A;
                        r_b        <= bus.B;
                        r_res      <= '0;
                        r_borrow   <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_res    <= w_res_next;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        // r_borrow here is the borrow into the MSB
                        r_d         <= w_res_next;
                        r_bo        <= w_bout;
                        r_v         <= r_borrow ^ w_bout;
                        r_z         <= (w_res_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.D         = r_d;
    assign bus.BORROW    = r_bo;
    assign bus.V         = r_v;
    assign bus.Z         = r_z;
endmodule
